muldiv: RTL



---
 rtl/muldiv_if.sv | 18 +
 rtl/muldiv.sv | 128 ++++++++++++
 2 files changed

// File: rtl/muldiv_if.sv
// Request/result bundle between the execute-stage control and the multiply/divide unit.
// Exposes the unit's FSM state for observation alongside the architectural HI/LO values.
interface muldiv_if;
  // start/funct/a/b are taken only on an edge where busy is low; a start while busy
  // is dropped, and done pulses for one cycle once HI/LO hold a new mul/div result.
  logic        start;
  logic [5:0]  funct;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [1:0]  state;

  modport master (output start, funct, a, b, input busy, done, hi, lo, state);
  modport slave  (input start, funct, a, b, output busy, done, hi, lo, state);
endinterface

// File: rtl/muldiv.sv
// Iterative 32-cycle multiply/divide unit with HI/LO registers.
// One shared 64-bit accumulator: shift-add for multiply, restoring steps for divide.
module muldiv (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);
  localparam logic [5:0] FUNC_MTHI  = 6'h11;
  localparam logic [5:0] FUNC_MTLO  = 6'h13;
  localparam logic [5:0] FUNC_MULT  = 6'h18;
  localparam logic [5:0] FUNC_MULTU = 6'h19;
  localparam logic [5:0] FUNC_DIV   = 6'h1A;
  localparam logic [5:0] FUNC_DIVU  = 6'h1B;

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, FIXUP = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [63:0] acc;
  logic [31:0] addend;
  logic [4:0]  count;
  logic        sa, sb, is_div, div_zero;
  logic [31:0] hi_q, lo_q;
  logic        done_q;

  logic        mul_op, div_op, signed_op;
  logic [31:0] a_abs, b_abs;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [33:0] div_diff;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix;

  always_comb begin
    mul_op    = (bus.funct == FUNC_MULT) || (bus.funct == FUNC_MULTU);
    div_op    = (bus.funct == FUNC_DIV)  || (bus.funct == FUNC_DIVU);
    signed_op = (bus.funct == FUNC_MULT) || (bus.funct == FUNC_DIV);
    a_abs     = (signed_op && bus.a[31]) ? 32'd0 - bus.a : bus.a;
    b_abs     = (signed_op && bus.b[31]) ? 32'd0 - bus.b : bus.b;
    // Multiply: acc[31:0] holds the multiplier shifting out LSB-first, addend is the multiplicand.
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, addend} : 33'd0);
    // Divide: acc[63:32] is the remainder, acc[31:0] shifts dividend out and quotient in.
    div_shift = {acc[63:32], acc[31]};
    div_diff  = {1'b0, div_shift} - {2'b00, addend};
    prod_fix  = (sa ^ sb) ? 64'd0 - acc : acc;
    quot_fix  = (sa ^ sb) ? 32'd0 - acc[31:0] : acc[31:0];
    // A zero divisor never borrows, so the remainder ends as |a| and the fixup restores a.
    rem_fix   = sa ? 32'd0 - acc[63:32] : acc[63:32];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start && mul_op)      state_d = MUL;
        else if (bus.start && div_op) state_d = DIV;
      end
      MUL:     if (count == 5'd31) state_d = FIXUP;
      DIV:     if (count == 5'd31) state_d = FIXUP;
      FIXUP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= 64'd0;
      addend   <= 32'd0;
      count    <= 5'd0;
      sa       <= 1'b0;
      sb       <= 1'b0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start && (mul_op || div_op)) begin
            sa       <= signed_op & bus.a[31];
            sb       <= signed_op & bus.b[31];
            is_div   <= div_op;
            div_zero <= div_op && (bus.b == 32'd0);
            count    <= 5'd0;
            addend   <= mul_op ? a_abs : b_abs;
            acc      <= {32'd0, mul_op ? b_abs : a_abs};
          end else if (bus.start && bus.funct == FUNC_MTHI) begin
            hi_q <= bus.a;
          end else if (bus.start && bus.funct == FUNC_MTLO) begin
            lo_q <= bus.a;
          end
        end
        MUL: begin
          acc   <= {mul_sum, acc[31:1]};
          count <= count + 5'd1;
        end
        DIV: begin
          if (div_diff[33]) acc <= {div_shift[31:0], acc[30:0], 1'b0};
          else              acc <= {div_diff[31:0], acc[30:0], 1'b1};
          count <= count + 5'd1;
        end
        FIXUP: begin
          if (is_div) begin
            lo_q <= div_zero ? 32'hFFFF_FFFF : quot_fix;
            hi_q <= rem_fix;
          end else begin
            lo_q <= prod_fix[31:0];
            hi_q <= prod_fix[63:32];
          end
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.state = state_q;
endmodule
